// File: rtl/axi_id_remap_table.sv
// axi_id_remap_table
// Binds each in-flight external ARID to a table row and grants a unique
// internal ID {row, col}. A free of that internal ID returns the original
// ARID through a registered, backpressured response.
//
// Ports
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   alloc_valid       : allocation request
//   alloc_id          : original ARID to bind
//   alloc_ready       : combinational grant available for alloc_id
//   alloc_uid         : granted {row,col}, zero when alloc_ready is low
//   free_valid        : free request
//   free_uid          : internal ID to release
//   free_ready        : free accepted this cycle (response slot available)
//   rsp_valid         : registered free response valid
//   rsp_id            : restored original ARID (zero on error)
//   rsp_err           : free hit an unused or out-of-range slot
//   rsp_ready         : response consumer ready
//   rows_bound        : per-row bound flags (registered)
//   total_used        : number of slots in use (registered)
module axi_id_remap_table #(
  parameter int ID_WIDTH = 4,
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 4,
  parameter int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  parameter int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  parameter int UID_W    = ROW_W + COL_W,
  parameter int CNT_W    = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_valid,
  input  logic [ID_WIDTH-1:0] alloc_id,
  output logic                alloc_ready,
  output logic [UID_W-1:0]    alloc_uid,
  input  logic                free_valid,
  input  logic [UID_W-1:0]    free_uid,
  output logic                free_ready,
  output logic                rsp_valid,
  output logic [ID_WIDTH-1:0] rsp_id,
  output logic                rsp_err,
  input  logic                rsp_ready,
  output logic [NUM_ROWS-1:0] rows_bound,
  output logic [CNT_W-1:0]    total_used
);

  // Table state
  logic [NUM_ROWS-1:0]                              bound_q, bound_d;
  logic [NUM_ROWS-1:0][ID_WIDTH-1:0]                bound_id_q, bound_id_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                used_q, used_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][ID_WIDTH-1:0]  tag_q, tag_d;

  // Response and status registers
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_WIDTH-1:0] rsp_id_q, rsp_id_d;
  logic                rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]    total_q, total_d;

  // Allocation selection
  logic                hit_found, empty_found, row_ok, col_ok;
  logic [ROW_W-1:0]    hit_row, empty_row, sel_row;
  logic [COL_W-1:0]    sel_col;
  logic [NUM_COLS-1:0] sel_used;
  logic                alloc_fire;

  // Free decode
  logic [ROW_W-1:0]    free_row;
  logic [COL_W-1:0]    free_col;
  logic                free_fire, free_ok;
  logic [ID_WIDTH-1:0] free_tag;

  assign free_ready = !rsp_valid_q || rsp_ready;
  assign free_fire  = free_valid && free_ready;
  assign free_row   = free_uid[UID_W-1:COL_W];
  assign free_col   = free_uid[COL_W-1:0];

  // Row select: an ID that is already bound must stay in its row, so a full
  // hit row blocks the grant instead of falling through to an empty row.
  always_comb begin
    hit_found   = 1'b0;
    hit_row     = '0;
    empty_found = 1'b0;
    empty_row   = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (!hit_found && bound_q[r] && (bound_id_q[r] == alloc_id)) begin
        hit_found = 1'b1;
        hit_row   = ROW_W'(r);
      end
      if (!empty_found && !bound_q[r]) begin
        empty_found = 1'b1;
        empty_row   = ROW_W'(r);
      end
    end
    row_ok  = hit_found || empty_found;
    sel_row = hit_found ? hit_row : empty_row;
  end

  // Column select: lowest clear bit of the selected row's registered bitmap
  always_comb begin
    sel_used = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (ROW_W'(r) == sel_row) begin
        sel_used = used_q[r];
      end
    end
    col_ok  = 1'b0;
    sel_col = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      if (!col_ok && !sel_used[c]) begin
        col_ok  = 1'b1;
        sel_col = COL_W'(c);
      end
    end
  end

  assign alloc_ready = row_ok && col_ok;
  assign alloc_uid   = alloc_ready ? {sel_row, sel_col} : '0;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // Free lookup by explicit compare, so out-of-range rows/columns (for
  // non-power-of-2 geometries) simply never match and report an error.
  always_comb begin
    free_ok  = 1'b0;
    free_tag = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        if ((ROW_W'(r) == free_row) && (COL_W'(c) == free_col) && used_q[r][c]) begin
          free_ok  = 1'b1;
          free_tag = tag_q[r][c];
        end
      end
    end
  end

  // Next-state for table, counters and response
  always_comb begin
    bound_d     = bound_q;
    bound_id_d  = bound_id_q;
    used_d      = used_q;
    tag_d       = tag_q;
    total_d     = total_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;

    // A valid free and an alloc never touch the same bit: the alloc picks a
    // clear bit of the registered map, the free clears a set one.
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
        if (free_fire && free_ok && (ROW_W'(r) == free_row) && (COL_W'(c) == free_col)) begin
          used_d[r][c] = 1'b0;
        end
        if (alloc_fire && (ROW_W'(r) == sel_row) && (COL_W'(c) == sel_col)) begin
          used_d[r][c] = 1'b1;
          tag_d[r][c]  = alloc_id;
        end
      end
    end

    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (alloc_fire && (ROW_W'(r) == sel_row) && !bound_q[r]) begin
        bound_d[r]    = 1'b1;
        bound_id_d[r] = alloc_id;
      end
      // A same-cycle alloc into this row sets a bit in used_d, which keeps
      // the row bound without a separate check.
      if (free_fire && free_ok && (ROW_W'(r) == free_row) && (used_d[r] == '0)) begin
        bound_d[r]    = 1'b0;
        bound_id_d[r] = '0;
      end
    end

    if (alloc_fire && !(free_fire && free_ok)) begin
      total_d = total_q + CNT_W'(1);
    end else if (!alloc_fire && free_fire && free_ok) begin
      total_d = total_q - CNT_W'(1);
    end

    if (free_fire) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = free_ok ? free_tag : '0;
      rsp_err_d   = !free_ok;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bound_q     <= '0;
      bound_id_q  <= '0;
      used_q      <= '0;
      tag_q       <= '0;
      total_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      bound_q     <= bound_d;
      bound_id_q  <= bound_id_d;
      used_q      <= used_d;
      tag_q       <= tag_d;
      total_q     <= total_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign rows_bound = bound_q;
  assign total_used = total_q;

endmodule
